arc4_seq_ctrl: RTL

//  Top-level sequencer for the ARC4 datapath: runs init -> ksa -> prga in order via
//  the en/rdy handshake and owns the single-port S memory, granting it to the active engine.

---
 rtl/arc4_seq_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/arc4_seq_ctrl.sv
// arc4_seq_ctrl: ARC4 top-level sequencer, runs init -> ksa -> prga and grants s_mem to the active engine
//  Optional watchdog: define ARC4_CTRL_WDOG_EN (per-stage limit WDOG_CYCLES, sticky err)
//  Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   en / rdy                    start request (taken only while rdy=1) / idle flag
//   stage                       0 idle, 1 init, 2 ksa, 3 prga
//   err                         sticky watchdog error (0 without ARC4_CTRL_WDOG_EN)
//   {init,ksa,prga}_en          one-cycle engine start pulses
//   {init,ksa,prga}_rdy         engine ready flags
//   {init,ksa,prga}_addr/wrdata/wren   engine S-mem requests
//   {init,ksa,prga}_rddata      s_rddata fanned out unchanged
//   s_addr, s_wrdata, s_wren    granted request to s_mem
//   s_rddata                    read data from s_mem
module arc4_seq_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [1:0]        stage,
  output logic              err,
  output logic              init_en,
  output logic              ksa_en,
  output logic              prga_en,
  input  logic              init_rdy,
  input  logic              ksa_rdy,
  input  logic              prga_rdy,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              init_wren,
  input  logic              ksa_wren,
  input  logic              prga_wren,
  output logic [DATA_W-1:0] init_rddata,
  output logic [DATA_W-1:0] ksa_rddata,
  output logic [DATA_W-1:0] prga_rddata,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren,
  input  logic [DATA_W-1:0] s_rddata
);
  // Encoding order matters: every GO is followed by its WAIT and every WAIT by the next stage's GO.
  typedef enum logic [2:0] {IDLE, I_GO, I_WAIT, K_GO, K_WAIT, P_GO, P_WAIT, DONE} state_t;
  state_t state, nxt;
  logic busy_seen, eng_rdy, go, wait_s, go_entry, timeout;
  logic [1:0] sel;
  always_comb begin
    sel = (state inside {I_GO, I_WAIT}) ? 2'd1 :
          (state inside {K_GO, K_WAIT}) ? 2'd2 :
          (state inside {P_GO, P_WAIT}) ? 2'd3 : 2'd0;
  end
  assign stage   = (state == DONE) ? 2'd3 : sel;
  assign rdy     = state == IDLE;
  assign go      = state inside {I_GO, K_GO, P_GO};
  assign wait_s  = state inside {I_WAIT, K_WAIT, P_WAIT};
  assign eng_rdy = (sel == 2'd1) ? init_rdy : (sel == 2'd2) ? ksa_rdy : prga_rdy;
  assign init_en = (state == I_GO) && init_rdy;
  assign ksa_en  = (state == K_GO) && ksa_rdy;
  assign prga_en = (state == P_GO) && prga_rdy;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:                   nxt = en ? I_GO : IDLE;
      I_GO, K_GO, P_GO:       nxt = eng_rdy ? state_t'(state + 3'd1) : state;
      I_WAIT, K_WAIT, P_WAIT: nxt = (busy_seen && eng_rdy) ? state_t'(state + 3'd1) : state;
      default:                nxt = IDLE;
    endcase
    if (timeout) nxt = IDLE;
  end
  assign go_entry = (nxt != state) && (nxt inside {I_GO, K_GO, P_GO});
  // An engine must be seen busy before its ready counts as completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy_seen <= 1'b0;
    end else begin
      state     <= nxt;
      busy_seen <= go_entry ? 1'b0 : (wait_s && !eng_rdy) ? 1'b1 : busy_seen;
    end
  end
`ifdef ARC4_CTRL_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES) + 1;
  logic [CW-1:0] cnt;
  logic err_q;
  assign timeout = (go || wait_s) && (cnt == CW'(WDOG_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= go_entry ? '0 : (go || wait_s) ? cnt + CW'(1) : cnt;
      err_q <= (rdy && en) ? 1'b0 : timeout ? 1'b1 : err_q;
    end
  end
  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0 & (WDOG_CYCLES == 0);
`endif
  assign s_addr   = (sel == 2'd1) ? init_addr : (sel == 2'd2) ? ksa_addr : (sel == 2'd3) ? prga_addr : '0;
  assign s_wrdata = (sel == 2'd1) ? init_wrdata : (sel == 2'd2) ? ksa_wrdata : (sel == 2'd3) ? prga_wrdata : '0;
  assign s_wren   = (sel == 2'd1) ? init_wren : (sel == 2'd2) ? ksa_wren : (sel == 2'd3) ? prga_wren : 1'b0;
  assign init_rddata = s_rddata;
  assign ksa_rddata  = s_rddata;
  assign prga_rddata = s_rddata;
endmodule
